y_serial_adder: RTL

//   Multi-cycle, parametrised N-bit adder/subtractor built on the 1-bit

---
 rtl/y_serial_adder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/y_serial_adder.sv
// Multi-cycle N-bit adder/subtractor that retires SLICE bits per clock, LSB first,
// behind a start/ready/done handshake. Provides subtract mode and signed overflow.
module y_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("y_serial_adder: WIDTH must be >= 1 and a multiple of SLICE");
    end

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] sum_s;
    logic             c_out_s;
    logic             c_msb_in_s;

    // Ripple through the current slice; operands are shifted so the slice is always the low bits.
    always_comb begin
        logic             c;
        logic             c_prev;
        logic [SLICE-1:0] s;
        logic [1:0]       r;
        c      = carry_q;
        c_prev = carry_q;
        s      = '0;
        for (int i = 0; i < SLICE; i++) begin
            c_prev = c;
            r      = full_add(a_q[i], b_q[i], c);
            s[i]   = r[0];
            c      = r[1];
        end
        sum_s      = s;
        c_out_s    = c;
        c_msb_in_s = c_prev;
    end

    // Handshake FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = c_out_s;
                // New slice enters at the top; after N slices z is in natural order.
                z_d     = (z_q >> SLICE) | (WIDTH'(sum_s) << (WIDTH - SLICE));
                if (cnt_q == LAST) begin
                    cout_d  = c_out_s;
                    ovf_d   = c_msb_in_s ^ c_out_s;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d != S_RUN);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign z     = z_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule
